// File: rtl/cocotb_array_pkg.sv
// Shared types for the array serializer: entry type and FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cocotb_array_pkg;

    // One array element as seen by the cocotb array tests.
    typedef logic [2:0] test_array_entry_t;

    // Serializer FSM: waiting for a frame, or holding one and emitting beats.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/cocotb_array_serializer.sv
// Captures a whole 2-D frame in one handshake, then streams it one entry per beat.
// Latency: first beat valid the cycle after load; NUM_ROWS*NUM_COLS cycles per frame at full rate.
// Backpressure: out_* held stable while out_ready is low; a new frame loads only on the last accepted beat or in IDLE.
module cocotb_array_serializer
    import cocotb_array_pkg::*;
#(
    parameter int  NUM_ROWS = 3,
    parameter int  NUM_COLS = 3,
    localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_col_major,
    input  test_array_entry_t in_arr_unpacked_unpacked [NUM_ROWS-1:0][NUM_COLS-1:0],
    output logic              out_valid,
    input  logic              out_ready,
    output test_array_entry_t out_entry,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              out_first,
    output logic              out_last,
    output test_array_entry_t out_parity,
    output logic              busy
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    ser_state_t        state_q, state_d;
    test_array_entry_t mem_q [NUM_ROWS-1:0][NUM_COLS-1:0];
    test_array_entry_t mem_d [NUM_ROWS-1:0][NUM_COLS-1:0];
    logic              col_major_q, col_major_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    test_array_entry_t acc_q, acc_d;
    logic              beat_acc;
    logic              load;

    // Beat fields and handshake outputs, all derived from registered state (plus out_ready at end of frame).
    always_comb begin
        out_valid  = (state_q == STREAM);
        busy       = out_valid;
        out_entry  = mem_q[row_q][col_q];
        out_parity = acc_q ^ out_entry;
        out_row    = row_q;
        out_col    = col_q;
        out_first  = out_valid && (acc_q == '0) && (row_q == '0) && (col_q == '0);
        out_last   = out_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
        in_ready   = (state_q == IDLE) || (out_valid && out_ready && out_last);
    end

    // Next state: load a frame, advance indices on accepted beats, return to IDLE after the last beat.
    always_comb begin
        beat_acc    = out_valid && out_ready;
        load        = in_valid && in_ready;
        state_d     = state_q;
        mem_d       = mem_q;
        col_major_d = col_major_q;
        row_d       = row_q;
        col_d       = col_q;
        acc_d       = acc_q;
        if (load) begin
            // Covers both IDLE loads and the same-cycle reload on the last beat.
            state_d     = STREAM;
            mem_d       = in_arr_unpacked_unpacked;
            col_major_d = in_col_major;
            row_d       = '0;
            col_d       = '0;
            acc_d       = '0;
        end else if (beat_acc) begin
            acc_d = out_parity;
            if (out_last) begin
                // Park indices and accumulator at zero so IDLE looks like post-reset.
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
                acc_d   = '0;
            end else if (col_major_q) begin
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                    col_d = col_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    // FSM, frame storage, indices and parity accumulator; reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            col_major_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            col_major_q <= col_major_d;
            row_q       <= row_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            mem_q       <= mem_d;
        end
    end

endmodule

// File: tb/tb_cocotb_array_serializer.sv
// Scoreboard bench for the array serializer: frames modelled on load, beats compared on acceptance.
// Latency: inputs driven 1ns after rising edge, outputs sampled on the falling edge.
// Backpressure: out_ready driven per scenario; stalls are checked for stable beat fields.
module tb_cocotb_array_serializer;
    import cocotb_array_pkg::*;

    localparam int R = 3;
    localparam int C = 3;

    typedef test_array_entry_t frame_t [R-1:0][C-1:0];

    typedef struct packed {
        test_array_entry_t entry;
        logic [1:0]        row;
        logic [1:0]        col;
        logic              first;
        logic              last;
        test_array_entry_t parity;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_col_major = 1'b0;
    frame_t            in_arr;
    logic              out_valid;
    logic              out_ready = 1'b0;
    test_array_entry_t out_entry;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_first;
    logic              out_last;
    test_array_entry_t out_parity;
    logic              busy;

    beat_t             sb[$];
    int                vectors = 0;
    int                miscompares = 0;
    test_array_entry_t last_par = '0;

    cocotb_array_serializer #(.NUM_ROWS(R), .NUM_COLS(C)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .in_col_major             (in_col_major),
        .in_arr_unpacked_unpacked (in_arr),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .out_entry                (out_entry),
        .out_row                  (out_row),
        .out_col                  (out_col),
        .out_first                (out_first),
        .out_last                 (out_last),
        .out_parity               (out_parity),
        .busy                     (busy)
    );

    always #5 clk = ~clk;

    task automatic set_ramp();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                in_arr[r][c] = test_array_entry_t'((3 * r + c) & 7);
    endtask

    task automatic set_const(input test_array_entry_t v);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                in_arr[r][c] = v;
    endtask

    // Model: expand the frame currently on the inputs into its expected beat sequence.
    task automatic push_frame();
        beat_t             b;
        test_array_entry_t p;
        int                n;
        int                r;
        int                c;
        p = '0;
        n = 0;
        for (int o = 0; o < (in_col_major ? C : R); o++) begin
            for (int i = 0; i < (in_col_major ? R : C); i++) begin
                r = in_col_major ? i : o;
                c = in_col_major ? o : i;
                p = p ^ in_arr[r][c];
                b.entry  = in_arr[r][c];
                b.row    = 2'(r);
                b.col    = 2'(c);
                b.first  = (n == 0);
                b.last   = (n == R * C - 1);
                b.parity = p;
                sb.push_back(b);
                n++;
            end
        end
    endtask

    // One clock: score an accepted beat, model a load, then step to just after the rising edge.
    task automatic cycle(output bit acc);
        beat_t e;
        beat_t g;
        @(negedge clk);
        acc = 1'b0;
        if (out_valid && out_ready) begin
            acc = 1'b1;
            g = '{out_entry, out_row, out_col, out_first, out_last, out_parity};
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: got e=%0d r=%0d c=%0d f=%0b l=%0b p=%0d, want none",
                         g.entry, g.row, g.col, g.first, g.last, g.parity);
            end else begin
                e = sb.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL beat: got e=%0d r=%0d c=%0d f=%0b l=%0b p=%0d, want e=%0d r=%0d c=%0d f=%0b l=%0b p=%0d",
                             g.entry, g.row, g.col, g.first, g.last, g.parity,
                             e.entry, e.row, e.col, e.first, e.last, e.parity);
                end
            end
            last_par = out_parity;
        end
        if (in_valid && in_ready) push_frame();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit acc;
        reset = 1'b1;
        #12;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy/vld/busy=%b, want 100", {in_ready, out_valid, busy});
        end
        vectors++;
        if ({out_first, out_last} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_marks: got first/last=%b, want 00", {out_first, out_last});
        end
        vectors++;
        if ({out_entry, out_row, out_col, out_parity} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_beat: got e=%0d r=%0d c=%0d p=%0d, want all 0", out_entry, out_row, out_col, out_parity);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(acc);
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset_idle: got rdy/vld=%b, want 10", {in_ready, out_valid});
        end
    endtask

    // Full frame at out_ready=1 in the given order; checks latency, frame length and final parity.
    task automatic test_frame(input bit cm);
        bit acc;
        int beats;
        int cyc;
        beats = 0;
        cyc = 0;
        set_ramp();
        in_col_major = cm;
        out_ready = 1'b1;
        in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL load_latency cm=%0b: got out_valid=%b, want 1", cm, out_valid);
        end
        while (beats < 9 && cyc < 40) begin
            cycle(acc);
            cyc++;
            if (acc) beats++;
        end
        vectors++;
        if (cyc !== 9 || beats !== 9) begin
            miscompares++;
            $display("FAIL frame_len cm=%0b: got %0d beats in %0d cycles, want 9 in 9", cm, beats, cyc);
        end
        vectors++;
        if (last_par !== 3'h0) begin
            miscompares++;
            $display("FAIL final_parity cm=%0b: got %0d, want 0", cm, last_par);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_frame cm=%0b: got busy=%b, want 0", cm, busy);
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        int beats;
        beats = 0;
        set_ramp();
        in_col_major = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && beats < 3; k++) begin
            cycle(acc);
            if (acc) beats++;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({out_valid, out_entry, out_row, out_col} !== {1'b1, 3'd3, 2'd1, 2'd0}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b e=%0d r=%0d c=%0d, want v=1 e=3 r=1 c=0",
                         k, out_valid, out_entry, out_row, out_col);
            end
            cycle(acc);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && beats < 9; k++) begin
            cycle(acc);
            if (acc) beats++;
        end
        vectors++;
        if (beats !== 9) begin
            miscompares++;
            $display("FAIL stall_frame_len: got %0d beats, want 9", beats);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int beats;
        beats = 0;
        set_ramp();
        in_col_major = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && beats < 8; k++) begin
            cycle(acc);
            if (acc) beats++;
        end
        set_const(3'h7);
        in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: got in_ready=%b out_last=%b, want 1 1", in_ready, out_last);
        end
        cycle(acc);
        if (acc) beats++;
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_first} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_no_bubble: got valid/first=%b, want 11", {out_valid, out_first});
        end
        for (int k = 0; k < 30 && beats < 18; k++) begin
            cycle(acc);
            if (acc) beats++;
        end
        vectors++;
        if (beats !== 18 || last_par !== 3'h7) begin
            miscompares++;
            $display("FAIL b2b_total: got %0d beats parity %0d, want 18 beats parity 7", beats, last_par);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        int beats;
        beats = 0;
        set_ramp();
        in_col_major = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && beats < 4; k++) begin
            cycle(acc);
            if (acc) beats++;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_mid: got vld/rdy/busy=%b, want 010", {out_valid, in_ready, busy});
        end
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_col_major = 1'b1;
        in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        vectors++;
        if ({out_first, out_row, out_col} !== 5'b1_00_00) begin
            miscompares++;
            $display("FAIL restart_first: got first=%b r=%0d c=%0d, want 1 0 0", out_first, out_row, out_col);
        end
        beats = 0;
        for (int k = 0; k < 20 && beats < 9; k++) begin
            cycle(acc);
            if (acc) beats++;
        end
        vectors++;
        if (beats !== 9) begin
            miscompares++;
            $display("FAIL restart_len: got %0d beats, want 9", beats);
        end
    endtask

    task automatic test_hold_busy();
        bit acc;
        int beats;
        beats = 0;
        set_ramp();
        in_col_major = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        cycle(acc);
        set_const(3'h5);
        in_col_major = 1'b1;
        for (int k = 0; k < 20 && beats < 8; k++) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_in_ready[%0d]: got %b, want 0", k, in_ready);
            end
            cycle(acc);
            if (acc) beats++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && beats < 9; k++) begin
            cycle(acc);
            if (acc) beats++;
        end
        vectors++;
        if (beats !== 9 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_hold_end: got %0d beats busy=%b, want 9 beats busy=0", beats, busy);
        end
    endtask

    initial begin
        set_const(3'h0);
        test_reset();
        test_frame(1'b0);
        test_frame(1'b1);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_hold_busy();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_beats: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
